// File: rtl/lfsr_edge_det.sv
// lfsr_edge_det
//   A maximal-length Fibonacci XNOR LFSR paired with an independent
//   single-bit edge detector. Both halves use the same clock and reset.
//   Each half has its own enable.
//
// Parameters:
//   WID   LFSR width. Only 8, 16, 22 and 32 are accepted; any other value
//         stops elaboration with an error.
//   INIT  Seed loaded on reset and on reseed. Must not be all-ones,
//         because all-ones is the lock-up state of an XNOR LFSR.
//
// Ports:
//   clk    in   1    clock; all state changes on its rising edge
//   rst    in   1    synchronous reset, active-low
//   ce     in   1    LFSR advance enable
//   cyc    in   1    LFSR reseed request (reloads INIT, overrides ce)
//   o      out  WID  LFSR state (direct register output)
//   ei_ce  in   1    edge-detector sample enable
//   i      in   1    edge-detector input
//   pe     out  1    positive edge of i
//   ne     out  1    negative edge of i
//   ee     out  1    either edge of i
//
// Build option:
//   EDGE_DET_REGOUT_EN  When defined, pe/ne/ee are registered. This adds
//                       one cycle of latency, and the registered outputs
//                       reset to 0. The LFSR is the same in both builds.

module lfsr_edge_det #(
    parameter int             WID  = 22,
    parameter logic [WID-1:0] INIT = 22'h0ACE3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           cyc,
    output logic [WID-1:0] o,
    input  logic           ei_ce,
    input  logic           i,
    output logic           pe,
    output logic           ne,
    output logic           ee
);

    // ------------------------------------------------------------------
    // Parameter guards
    // ------------------------------------------------------------------
    if (WID != 8 && WID != 16 && WID != 22 && WID != 32) begin : g_bad_wid
        $error("lfsr_edge_det: unsupported WID %0d", WID);
    end

    if (INIT == {WID{1'b1}}) begin : g_bad_init
        $error("lfsr_edge_det: INIT must not be all-ones");
    end

    // ------------------------------------------------------------------
    // LFSR feedback
    // Taps are 1-based in the usual tables, so tap n is o[n-1]. XNOR
    // feedback makes all-zeros a legal state and all-ones the stuck state.
    // ------------------------------------------------------------------
    logic fb;
    logic all_ones;

    if (WID == 8) begin : g_fb8
        assign fb = ~(o[7] ^ o[5] ^ o[4] ^ o[3]);
    end else if (WID == 16) begin : g_fb16
        assign fb = ~(o[15] ^ o[14] ^ o[12] ^ o[3]);
    end else if (WID == 22) begin : g_fb22
        assign fb = ~(o[21] ^ o[20]);
    end else begin : g_fb32
        assign fb = ~(o[31] ^ o[21] ^ o[1] ^ o[0]);
    end

    assign all_ones = &o;

    // ------------------------------------------------------------------
    // LFSR register
    // Priority order is reset, then reseed, then advance. On an advance
    // out of the all-ones state, the register reloads the seed so that it
    // can never get stuck.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            o <= INIT;
        end else if (cyc) begin
            o <= INIT;
        end else if (ce) begin
            if (all_ones) begin
                o <= INIT;
            end else begin
                o <= {o[WID-2:0], fb};
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detector history
    // q holds the last sampled i. While ei_ce is low, q keeps its value,
    // so the edge outputs compare the live i against that stale sample.
    // ------------------------------------------------------------------
    logic q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (ei_ce) begin
            q <= i;
        end
    end

    logic pe_c;
    logic ne_c;
    logic ee_c;

    assign pe_c = i & ~q;
    assign ne_c = ~i & q;
    assign ee_c = i ^ q;

`ifdef EDGE_DET_REGOUT_EN
    // Registered outputs: each pulse appears one cycle after the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pe <= 1'b0;
            ne <= 1'b0;
            ee <= 1'b0;
        end else begin
            pe <= pe_c;
            ne <= ne_c;
            ee <= ee_c;
        end
    end
`else
    // Zero-latency outputs. These also stay live during reset.
    assign pe = pe_c;
    assign ne = ne_c;
    assign ee = ee_c;
`endif

endmodule

// File: tb/tb_lfsr_edge_det.sv
// tb_lfsr_edge_det
//   Self-checking bench for lfsr_edge_det. The bench uses two instances:
//   - The default WID=22 instance receives directed and random stimulus.
//   - A WID=8, INIT=1 instance covers the full period and the lock-up guard.
//   A behavioural model computes every expected value. The model derives
//   the LFSR step from tap masks with plain arithmetic, and it models the
//   edge detector as "previous sampled value versus current input".

module tb_lfsr_edge_det;

    logic        clk = 1'b0;
    logic        rst, ce, cyc, ei_ce, i;
    logic [21:0] o;
    logic        pe, ne, ee;

    logic        rst8, ce8, cyc8;
    logic [7:0]  o8;
    logic        pe8, ne8, ee8;

    int checks = 0;
    int errors = 0;

    // Model state for the WID=22 instance.
    logic [31:0] m_o;
    logic        m_q;
    logic        m_pe_r, m_ne_r, m_ee_r;

    // Values observed in the most recent applyStimulus call. Directed
    // checks compare these against constants.
    logic        obs_pe, obs_ne, obs_ee;

    always #5 clk = ~clk;

    lfsr_edge_det dut (
        .clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o),
        .ei_ce(ei_ce), .i(i), .pe(pe), .ne(ne), .ee(ee)
    );

    lfsr_edge_det #(.WID(8), .INIT(8'h01)) dut8 (
        .clk(clk), .rst(rst8), .ce(ce8), .cyc(cyc8), .o(o8),
        .ei_ce(1'b0), .i(1'b0), .pe(pe8), .ne(ne8), .ee(ee8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One LFSR advance: the seed is reloaded out of all-ones. Otherwise the
    // state shifts left and takes XNOR parity of the tapped bits.
    function automatic logic [31:0] lfsrNext(input logic [31:0] s, input int w,
                                             input logic [31:0] mask,
                                             input logic [31:0] seed);
        logic [31:0] full;
        logic        fbit;
        full = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (s == full) return seed;
        fbit = ~(^(s & mask));
        return ((s << 1) | {31'd0, fbit}) & full;
    endfunction

    // Drive one cycle on the WID=22 instance and check it against the model:
    // edge outputs just after the inputs settle, LFSR state after the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic y,
                                 input logic e, input logic ii);
        logic exp_pe, exp_ne, exp_ee;
        logic c_pe, c_ne, c_ee;
        @(negedge clk);
        rst = r; ce = c; cyc = y; ei_ce = e; i = ii;
        #1;
        c_pe = ii & ~m_q;
        c_ne = ~ii & m_q;
        c_ee = ii ^ m_q;
`ifdef EDGE_DET_REGOUT_EN
        exp_pe = m_pe_r; exp_ne = m_ne_r; exp_ee = m_ee_r;
`else
        exp_pe = c_pe; exp_ne = c_ne; exp_ee = c_ee;
`endif
        obs_pe = pe; obs_ne = ne; obs_ee = ee;
        checkOutput("pe", {31'd0, pe}, {31'd0, exp_pe});
        checkOutput("ne", {31'd0, ne}, {31'd0, exp_ne});
        checkOutput("ee", {31'd0, ee}, {31'd0, exp_ee});
        @(posedge clk);
        if (!r) begin
            m_pe_r = 1'b0; m_ne_r = 1'b0; m_ee_r = 1'b0;
        end else begin
            m_pe_r = c_pe; m_ne_r = c_ne; m_ee_r = c_ee;
        end
        m_q = !r ? 1'b0 : (e ? ii : m_q);
        if (!r || y)   m_o = 32'h0ACE3;
        else if (c)    m_o = lfsrNext(m_o, 22, 32'h0030_0000, 32'h0ACE3);
        #1;
        checkOutput("o", {10'd0, o}, m_o);
    endtask

    initial begin
        logic [31:0] m8;
        rst = 1'b0; ce = 1'b0; cyc = 1'b0; ei_ce = 1'b0; i = 1'b0;
        rst8 = 1'b0; ce8 = 1'b0; cyc8 = 1'b0;
        m_o = 32'h0ACE3; m_q = 1'b0;
        m_pe_r = 1'b0; m_ne_r = 1'b0; m_ee_r = 1'b0;

        // Reset for two clocks, then advance twice.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_o", {10'd0, o}, 32'h0ACE3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("step1_o", {10'd0, o}, 32'h159C7);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("step2_o", {10'd0, o}, 32'h2B38F);

        // Hold with ce low, then reseed while ce is high.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_o", {10'd0, o}, 32'h2B38F);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reseed_o", {10'd0, o}, 32'h0ACE3);

        // Directed edge sequence with ei_ce held high.
        begin
            logic [4:0] seq_i;
            logic [4:0] exp_pe_seq, exp_ne_seq, exp_ee_seq;
            seq_i = 5'b00110;  // bit k is cycle k: 0,1,1,0,0
`ifdef EDGE_DET_REGOUT_EN
            exp_pe_seq = 5'b00100;
            exp_ne_seq = 5'b10000;
            exp_ee_seq = 5'b10100;
`else
            exp_pe_seq = 5'b00010;
            exp_ne_seq = 5'b01000;
            exp_ee_seq = 5'b01010;
`endif
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, seq_i[k]);
                checkOutput("seq_pe", {31'd0, obs_pe}, {31'd0, exp_pe_seq[k]});
                checkOutput("seq_ne", {31'd0, obs_ne}, {31'd0, exp_ne_seq[k]});
                checkOutput("seq_ee", {31'd0, obs_ee}, {31'd0, exp_ee_seq[k]});
            end
        end

        // Random stimulus against the model, with occasional reset and reseed.
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 19) != 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7,
                          1'($urandom));
        end

        // Full period of the 8-bit instance.
        @(negedge clk); rst8 = 1'b0;
        @(negedge clk); rst8 = 1'b1; ce8 = 1'b1;
        checkOutput("p8_reset_o", {24'd0, o8}, 32'h01);
        m8 = 32'h01;
        for (int k = 1; k <= 255; k++) begin
            @(posedge clk); #1;
            m8 = lfsrNext(m8, 8, 32'h0000_00B8, 32'h01);
            checkOutput("p8_o", {24'd0, o8}, m8);
            if (k < 255)
                checkOutput("p8_no_early_or_ff", {31'd0, (o8 == 8'h01) || (o8 == 8'hFF)}, 32'd0);
        end
        checkOutput("p8_period", {24'd0, o8}, 32'h01);

        // Lock-up guard: park the register at all-ones, then advance once.
        @(negedge clk);
        ce8 = 1'b1;
        force dut8.o = 8'hFF;
        #1;
        release dut8.o;
        #1;
        checkOutput("lockup_forced", {24'd0, o8}, 32'hFF);
        @(posedge clk); #1;
        checkOutput("lockup_recover", {24'd0, o8}, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_edge_det.md
Name: lfsr_edge_det

Overview:
- Utility block pairing a maximal-length pseudo-random generator with a single-bit edge detector.
- Cache tag memories use the LFSR low bits to pick a replacement way.
- Cache write paths use the edge detector to raise a one-shot pulse on the first beat of a line load.
- Both halves share one clock and one reset. They are otherwise independent and each has its own enable.

Parameters:
- WID, 22, LFSR width; supported values 8, 16, 22, 32. Any other value is a synthesis-time error.
- INIT, 22'h0ACE3, seed loaded on reset and on reseed; width WID. Must not be all-ones.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- ce  in  1  LFSR advance enable
- cyc  in  1  LFSR reseed request; synchronously reloads INIT
- o  out  WID  LFSR state
- ei_ce  in  1  edge-detector sample enable
- i  in  1  edge-detector input
- pe  out  1  positive edge of i
- ne  out  1  negative edge of i
- ee  out  1  either edge of i

Behaviour:
- LFSR is Fibonacci XNOR type and shifts left: o <= {o[WID-2:0], fb}.
- fb = XNOR of the tapped bits (1-based, bit n = o[n-1]):
  - WID 8: taps 8,6,5,4
  - WID 16: taps 16,15,13,4
  - WID 22: taps 22,21
  - WID 32: taps 32,22,2,1
- LFSR update priority, evaluated each clk:
  1. rst=0 → o <= INIT.
  2. else cyc=1 → o <= INIT (independent of ce).
  3. else ce=1 → shift.
  4. else hold.
- Lock-up guard: if o is all-ones and ce=1, next o = INIT instead of a shift.
- o is a direct register output with no combinational path from inputs. Reset value is INIT.
- Period is 2^WID-1 ce-steps. The sequence returns to INIT after exactly that many advances.
- Edge detector keeps one register q:
  - rst=0 → q <= 0.
  - else ei_ce=1 → q <= i.
  - else hold.
- Edge outputs are combinational: pe = i & ~q; ne = ~i & q; ee = i ^ q.
- Zero-latency: a rising i produces pe in the same cycle.
- With ei_ce held at 1, each pulse lasts one cycle. With ei_ce=0, q is frozen and pe/ne/ee follow i against the stale q.
- During reset pe/ne/ee still reflect i against q. q reads 0 after reset, so i=1 on the first post-reset cycle gives pe=1, ee=1, ne=0.
- Reset asserted mid-sequence: the LFSR returns to INIT and q to 0 on the next edge; no other state exists.

Optional Feature:
- Macro EDGE_DET_REGOUT_EN.
- When defined: pe/ne/ee are registered (computed from i and q, captured on clk). This adds one cycle of latency, and all three reset to 0.
- When undefined: outputs are combinational as above.
- LFSR behaviour is identical in both builds.

Test Plan:
- Reset with WID=22, INIT=0x0ACE3: hold rst=0 for 2 clks → o=0x0ACE3. Release rst, ce=1 → o=0x159C7, then 0x2B38F.
- ce=0 for 5 clks after the above → o stays 0x2B38F. Then cyc=1 with ce=1 for 1 clk → o=0x0ACE3.
- Period check, WID=8, INIT=8'h01: advance 255 times → o=0x01 again. No repeat earlier, and the all-ones state is never reached.
- Lock-up guard: force o to all-ones via a WID=8 instance with INIT override in a separate bench build, ce=1 → next o = INIT.
- Edge detector, ei_ce=1: i sequence 0,1,1,0,0 → pe 0,1,0,0,0; ne 0,0,0,1,0; ee 0,1,0,1,0.
- Build with EDGE_DET_REGOUT_EN: same i sequence → each output delayed one clk. Assert rst=0 → pe=ne=ee=0 on the next clk.
